irq_arbiter: RTL and testbench
==============================

Name: irq_arbiter

Overview:
- Memory-mapped interrupt controller on the 8-bit processor bus.
- Collects up to NUM_SRC peripheral interrupt requests and shares one processor interrupt line between them: rising-edge latch, per-source enable, fixed priority (lowest index wins), one request in service at a time.
- Software reads the serviced source ID over the bus.
- Returns the processor acknowledge to the granted peripheral only.

Parameters:
- NUM_SRC, 4, number of request sources, 1..8.
- BASE_ADDR, 8'hF8, bus base address of the 4-register window; low 2 bits must be 0.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset asserted).
- BUS_DATA  inout  8  shared bus data; driven only during a register read, else high-Z.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  1 = write cycle, 0 = read cycle.
- SRC_IRQ_RAISE  in  NUM_SRC  per-source request level; held by the peripheral until its ack.
- SRC_IRQ_ACK  out  NUM_SRC  per-source acknowledge, single-cycle pulse.
- CPU_IRQ_RAISE  out  1  interrupt request to the processor.
- CPU_IRQ_ACK  in  1  processor acknowledge of CPU_IRQ_RAISE.

Behaviour:
- Reset (RESET=0, async):
  - ENABLE=0, PENDING=0, ACTIVE=8'hFF, src_dly=0.
  - FSM=IDLE, CPU_IRQ_RAISE=0, SRC_IRQ_ACK=0.
  - BUS_DATA high-Z.
  - Reset mid-service drops CPU_IRQ_RAISE immediately and issues no SRC ack.
- Register map (offset from BASE_ADDR):
  - +0 ENABLE: RW.
  - +1 PENDING: read = pending bits; write = write-1-to-clear.
  - +2 ACTIVE: RO; ID of last granted source, 8'hFF before the first grant; writes ignored.
  - +3 FORCE: WO, reads 0; write-1 sets pending (software trigger).
  - Bits at index >= NUM_SRC read 0, and writes to them are ignored.
- Bus write: when BUS_WE=1 and address is in the window at edge k, the register updates at edge k.
- Bus read: when BUS_WE=0 and address is in the window at edge k, the register value is captured and the output enable is registered. BUS_DATA is driven from after edge k until edge k+1, then returns to high-Z.
- Edge detect:
  - src_dly <= SRC_IRQ_RAISE every cycle.
  - rise = SRC_IRQ_RAISE & ~src_dly.
  - PENDING[i] is set at the edge that samples rise[i]=1, and also by FORCE.
  - A level held high does not re-set PENDING after it is cleared.
  - Set beats clear (W1C or service) in the same cycle.
  - Pending latches regardless of ENABLE; masking only gates arbitration.
- FSM, IDLE:
  - If req = PENDING & ENABLE is nonzero: sel = lowest set index; ACTIVE <= sel; CPU_IRQ_RAISE <= 1; go to WAIT_ACK.
  - Latency: source rise sampled at edge k -> PENDING at k -> CPU_IRQ_RAISE high after edge k+1.
- FSM, WAIT_ACK:
  - CPU_IRQ_RAISE is held at 1.
  - If CPU_IRQ_ACK=1: CPU_IRQ_RAISE <= 0; PENDING[ACTIVE] <= 0; SRC_IRQ_ACK[ACTIVE] <= 1 for exactly one cycle; go to HOLDOFF.
  - Else if PENDING[ACTIVE] & ENABLE[ACTIVE] becomes 0 (W1C or mask): withdraw; CPU_IRQ_RAISE <= 0; no SRC ack; ACTIVE unchanged; go to IDLE.
  - Ack and withdraw in the same cycle: ack wins.
  - Higher-priority requests arriving in WAIT_ACK do not preempt; they stay pending.
- FSM, HOLDOFF:
  - One cycle with CPU_IRQ_RAISE=0, so the processor sees a falling edge between grants.
  - Then go to IDLE.
- ACTIVE holds the last grant through the ISR until the next grant.
- CPU_IRQ_ACK outside WAIT_ACK is ignored.

Test Plan:
- Reset then read +0/+1/+2/+3 -> 00, 00, FF, 00; BUS_DATA high-Z outside the read cycle; CPU_IRQ_RAISE=0.
- ENABLE=0F; raise SRC[2] at edge k -> PENDING=04 at k; CPU_IRQ_RAISE=1 after k+1; ACTIVE=02; CPU_IRQ_ACK 1 cycle -> SRC_IRQ_ACK=0100 for 1 cycle; PENDING=00; RAISE low for >= 1 cycle.
- ENABLE=0F; raise SRC[3] and SRC[1] on the same edge -> grant 1, ack; then grant 3 after HOLDOFF; ACTIVE sequence 01, 03.
- ENABLE=00; raise SRC[0] -> PENDING=01, no CPU raise; write ENABLE=01 -> CPU_IRQ_RAISE within 2 cycles.
- In WAIT_ACK for src 0, write PENDING=01 (W1C) -> raise drops next cycle, no SRC_IRQ_ACK, FSM IDLE; repeat with ack and W1C in the same cycle -> ack path taken.
- Write FORCE=08 with ENABLE=08 -> grant ID 03; assert RESET=0 mid-WAIT_ACK -> CPU_IRQ_RAISE=0 asynchronously; all registers return to reset values.

Source files
------------

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : irq_arbiter
// Purpose : Bus-mapped interrupt controller. Edge-latches peripheral requests,
//           grants one at a time (lowest index first) to the CPU line.
// Revision: 1.0 - initial release
// ============================================================================
module irq_arbiter #(
  parameter int          NUM_SRC   = 4,
  parameter logic [7:0]  BASE_ADDR = 8'hF8
) (
  input  logic               CLK,
  input  logic               RESET,
  inout  wire  [7:0]         BUS_DATA,
  input  logic [7:0]         BUS_ADDR,
  input  logic               BUS_WE,
  input  logic [NUM_SRC-1:0] SRC_IRQ_RAISE,
  output logic [NUM_SRC-1:0] SRC_IRQ_ACK,
  output logic               CPU_IRQ_RAISE,
  input  logic               CPU_IRQ_ACK
);

  localparam logic [1:0] C_OFF_ENABLE  = 2'd0;
  localparam logic [1:0] C_OFF_PENDING = 2'd1;
  localparam logic [1:0] C_OFF_ACTIVE  = 2'd2;
  localparam logic [1:0] C_OFF_FORCE   = 2'd3;
  localparam logic [7:0] C_NO_GRANT    = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_HOLDOFF  = 2'd2
  } state_t;

  state_t             r_state;
  logic [NUM_SRC-1:0] r_enable;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_src_dly;
  logic [NUM_SRC-1:0] r_src_ack;
  logic [7:0]         r_active;
  logic               r_cpu_raise;
  logic [7:0]         r_rd_data;
  logic               r_rd_oe;

  logic               w_hit;
  logic               w_wr_enable;
  logic               w_wr_pending;
  logic               w_wr_force;
  logic               w_rd;
  logic [NUM_SRC-1:0] w_wdata;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_svc_clr;
  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_act_oh;
  logic               w_act_live;
  logic [7:0]         w_sel;
  logic [7:0]         w_rd_val;
  logic               w_unused;

  // Bus decode: the window is four bytes aligned on BASE_ADDR.
  assign w_hit        = (BUS_ADDR[7:2] == BASE_ADDR[7:2]);
  assign w_wr_enable  = w_hit && BUS_WE && (BUS_ADDR[1:0] == C_OFF_ENABLE);
  assign w_wr_pending = w_hit && BUS_WE && (BUS_ADDR[1:0] == C_OFF_PENDING);
  assign w_wr_force   = w_hit && BUS_WE && (BUS_ADDR[1:0] == C_OFF_FORCE);
  assign w_rd         = w_hit && !BUS_WE;
  assign w_wdata      = BUS_DATA[NUM_SRC-1:0];
  assign w_unused     = ^BUS_DATA;

  assign BUS_DATA = r_rd_oe ? r_rd_data : 8'hzz;

  assign w_rise    = SRC_IRQ_RAISE & ~r_src_dly;
  assign w_set     = w_rise | (w_wr_force ? w_wdata : '0);
  assign w_svc_clr = ((r_state == S_WAIT_ACK) && CPU_IRQ_ACK) ? w_act_oh : '0;
  assign w_clr     = (w_wr_pending ? w_wdata : '0) | w_svc_clr;
  assign w_req     = r_pending & r_enable;

  always_comb begin
    w_act_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_act_oh[i] = (r_active == 8'(i));
    end
  end

  assign w_act_live = |(w_act_oh & r_pending & r_enable);

  // Scan from the top so the lowest requesting index is the last to win.
  always_comb begin
    w_sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_sel = 8'(i);
      end
    end
  end

  always_comb begin
    w_rd_val = '0;
    case (BUS_ADDR[1:0])
      C_OFF_ENABLE:  w_rd_val[NUM_SRC-1:0] = r_enable;
      C_OFF_PENDING: w_rd_val[NUM_SRC-1:0] = r_pending;
      C_OFF_ACTIVE:  w_rd_val              = r_active;
      default:       w_rd_val              = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_enable  <= '0;
      r_pending <= '0;
      r_src_dly <= '0;
      r_rd_data <= '0;
      r_rd_oe   <= 1'b0;
    end else begin
      r_src_dly <= SRC_IRQ_RAISE;
      // New sets take precedence over any clear landing in the same cycle.
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_wr_enable) begin
        r_enable <= w_wdata;
      end
      r_rd_oe <= w_rd;
      if (w_rd) begin
        r_rd_data <= w_rd_val;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_cpu_raise <= 1'b0;
      r_src_ack   <= '0;
      r_active    <= C_NO_GRANT;
    end else begin
      r_src_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (|w_req) begin
            r_active    <= w_sel;
            r_cpu_raise <= 1'b1;
            r_state     <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (CPU_IRQ_ACK) begin
            r_cpu_raise <= 1'b0;
            r_src_ack   <= w_act_oh;
            r_state     <= S_HOLDOFF;
          end else if (!w_act_live) begin
            // Request was cleared or masked before the CPU took it.
            r_cpu_raise <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_HOLDOFF: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_cpu_raise <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign SRC_IRQ_ACK   = r_src_ack;
  assign CPU_IRQ_RAISE = r_cpu_raise;

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_irq_arbiter
// Purpose : Scoreboard bench for irq_arbiter (bus reads and source acks).
// Revision: 1.0 - initial release
// ============================================================================
module tb_irq_arbiter;

  localparam int         NUM_SRC = 4;
  localparam logic [7:0] BASE    = 8'hF8;

  logic               clk = 1'b0;
  logic               reset_n;
  wire  [7:0]         bus_data;
  logic [7:0]         bus_addr;
  logic               bus_we;
  logic [7:0]         tb_wdata;
  logic               tb_drv;
  logic [NUM_SRC-1:0] src_raise;
  logic [NUM_SRC-1:0] src_ack;
  logic               cpu_raise;
  logic               cpu_ack;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]         rd_q[$];
  logic [NUM_SRC-1:0] ack_q[$];

  assign bus_data = tb_drv ? tb_wdata : 8'hzz;

  always #5 clk = ~clk;

  irq_arbiter #(.NUM_SRC(NUM_SRC), .BASE_ADDR(BASE)) dut (
    .CLK          (clk),
    .RESET        (reset_n),
    .BUS_DATA     (bus_data),
    .BUS_ADDR     (bus_addr),
    .BUS_WE       (bus_we),
    .SRC_IRQ_RAISE(src_raise),
    .SRC_IRQ_ACK  (src_ack),
    .CPU_IRQ_RAISE(cpu_raise),
    .CPU_IRQ_ACK  (cpu_ack)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All tasks are entered on a falling edge and return on a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [1:0] off, input logic [7:0] data);
    bus_addr = BASE | {6'b0, off};
    bus_we   = 1'b1;
    tb_wdata = data;
    tb_drv   = 1'b1;
    @(negedge clk);
    bus_we   = 1'b0;
    tb_drv   = 1'b0;
    bus_addr = 8'h00;
  endtask

  task automatic bus_rd(input string tag, input logic [1:0] off, input logic [7:0] exp);
    rd_q.push_back(exp);
    bus_addr = BASE | {6'b0, off};
    bus_we   = 1'b0;
    @(negedge clk);
    check_val(tag, {24'b0, bus_data}, {24'b0, rd_q.pop_front()});
    bus_addr = 8'h00;
    @(negedge clk);
  endtask

  task automatic cpu_take(input logic [NUM_SRC-1:0] exp_ack);
    ack_q.push_back(exp_ack);
    cpu_ack = 1'b1;
    @(negedge clk);
    cpu_ack = 1'b0;
  endtask

  // Every nonzero source-ack cycle must match one queued expectation.
  always @(negedge clk) begin
    if (src_ack != '0) begin
      if (ack_q.size() == 0) begin
        check_val("src_ack_unexpected", {28'b0, src_ack}, 32'h0);
      end else begin
        check_val("src_ack", {28'b0, src_ack}, {28'b0, ack_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    bus_addr  = 8'h00;
    bus_we    = 1'b0;
    tb_wdata  = 8'h00;
    tb_drv    = 1'b0;
    src_raise = '0;
    cpu_ack   = 1'b0;
    tick(2);
    check_val("rst_cpu_raise", {31'b0, cpu_raise}, 32'h0);
    check_val("rst_src_ack", {28'b0, src_ack}, 32'h0);
    reset_n = 1'b1;
    tick(1);

    // Reset values and register access rules
    bus_rd("rst_enable", 2'd0, 8'h00);
    bus_rd("rst_pending", 2'd1, 8'h00);
    bus_rd("rst_active", 2'd2, 8'hFF);
    bus_rd("rst_force", 2'd3, 8'h00);
    bus_wr(2'd0, 8'hFF);
    bus_rd("enable_upper_bits", 2'd0, 8'h0F);
    bus_wr(2'd2, 8'h55);
    bus_rd("active_ro", 2'd2, 8'hFF);
    check_val("idle_cpu_raise", {31'b0, cpu_raise}, 32'h0);

    // Single source: latency, ack pulse, holdoff
    src_raise = 4'b0100;
    tick(1);
    check_val("s2_raise_k", {31'b0, cpu_raise}, 32'h0);
    tick(1);
    check_val("s2_raise_k1", {31'b0, cpu_raise}, 32'h1);
    bus_rd("s2_active", 2'd2, 8'h02);
    bus_rd("s2_pending", 2'd1, 8'h04);
    cpu_take(4'b0100);
    src_raise = '0;
    check_val("s2_raise_drop", {31'b0, cpu_raise}, 32'h0);
    tick(1);
    check_val("s2_holdoff", {31'b0, cpu_raise}, 32'h0);
    bus_rd("s2_pending_clr", 2'd1, 8'h00);

    // Two sources on one edge: lowest index first, then the other
    src_raise = 4'b1010;
    tick(2);
    check_val("p_raise1", {31'b0, cpu_raise}, 32'h1);
    bus_rd("p_active1", 2'd2, 8'h01);
    cpu_take(4'b0010);
    src_raise = '0;
    check_val("p_drop1", {31'b0, cpu_raise}, 32'h0);
    tick(1);
    check_val("p_holdoff", {31'b0, cpu_raise}, 32'h0);
    tick(1);
    check_val("p_raise3", {31'b0, cpu_raise}, 32'h1);
    bus_rd("p_active3", 2'd2, 8'h03);
    cpu_take(4'b1000);
    check_val("p_drop3", {31'b0, cpu_raise}, 32'h0);
    tick(2);
    bus_rd("p_pending", 2'd1, 8'h00);

    // Masked pending latches; enabling releases it
    bus_wr(2'd0, 8'h00);
    src_raise = 4'b0001;
    tick(3);
    check_val("mask_no_raise", {31'b0, cpu_raise}, 32'h0);
    bus_rd("mask_pending", 2'd1, 8'h01);
    bus_wr(2'd0, 8'h01);
    check_val("unmask_raise_k", {31'b0, cpu_raise}, 32'h0);
    tick(1);
    check_val("unmask_raise_k1", {31'b0, cpu_raise}, 32'h1);

    // Withdraw by W1C while waiting for the CPU
    bus_wr(2'd1, 8'h01);
    check_val("w1c_raise_hold", {31'b0, cpu_raise}, 32'h1);
    tick(1);
    check_val("w1c_withdraw", {31'b0, cpu_raise}, 32'h0);
    bus_rd("w1c_active", 2'd2, 8'h00);
    bus_rd("w1c_pending", 2'd1, 8'h00);
    check_val("w1c_idle", {31'b0, cpu_raise}, 32'h0);

    // Ack and W1C in the same cycle: ack path
    bus_wr(2'd3, 8'h01);
    tick(1);
    check_val("race_raise", {31'b0, cpu_raise}, 32'h1);
    ack_q.push_back(4'b0001);
    bus_addr = BASE | 8'h01;
    bus_we   = 1'b1;
    tb_wdata = 8'h01;
    tb_drv   = 1'b1;
    cpu_ack  = 1'b1;
    @(negedge clk);
    bus_we   = 1'b0;
    tb_drv   = 1'b0;
    bus_addr = 8'h00;
    cpu_ack  = 1'b0;
    check_val("race_drop", {31'b0, cpu_raise}, 32'h0);
    tick(2);
    check_val("race_stay_low", {31'b0, cpu_raise}, 32'h0);
    bus_rd("race_pending", 2'd1, 8'h00);
    src_raise = '0;

    // Software trigger, then asynchronous reset mid-service
    bus_wr(2'd0, 8'h08);
    bus_wr(2'd3, 8'h08);
    tick(1);
    check_val("force_raise", {31'b0, cpu_raise}, 32'h1);
    bus_rd("force_active", 2'd2, 8'h03);
    bus_rd("force_reads0", 2'd3, 8'h00);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_rst_raise", {31'b0, cpu_raise}, 32'h0);
    check_val("async_rst_ack", {28'b0, src_ack}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(1);
    bus_rd("post_rst_enable", 2'd0, 8'h00);
    bus_rd("post_rst_pending", 2'd1, 8'h00);
    bus_rd("post_rst_active", 2'd2, 8'hFF);
    bus_rd("post_rst_force", 2'd3, 8'h00);
    check_val("post_rst_raise", {31'b0, cpu_raise}, 32'h0);

    tick(2);
    check_val("ack_q_drained", ack_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
